// File: rtl/interp_pkg.sv
// Shared types and constants for the interpolation transposed buffer.
// Latency: n/a. Backpressure: n/a.
package interp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] COL_FIRST = 3'd2;
    localparam logic [2:0] COL_LAST  = 3'd5;
    localparam logic [2:0] SEL_IDLE  = 3'd0;

    localparam int ROW_W    = 99;
    localparam int SAMPLE_W = 9;

endpackage

// File: rtl/transposed_buffer_ctrl.sv
// Fills the transposed buffer row by row, then walks the column select COL_FIRST..COL_LAST.
// Latency: SELECT valid the cycle after the last row write; DONE the cycle after the COL_LAST handshake.
// Backpressure: in_valid=0 stalls the fill, out_ready=0 holds the current column.
module transposed_buffer_ctrl #(
    parameter int         FILL_ROWS = 11,
    parameter logic [2:0] COL_FIRST = interp_pkg::COL_FIRST,
    parameter logic [2:0] COL_LAST  = interp_pkg::COL_LAST
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       wr_en,
    output logic [3:0] wr_row,
    output logic [2:0] select,
    output logic       rd_valid,
    output logic       done
);
    import interp_pkg::*;

    localparam logic [3:0] LAST_ROW = 4'(FILL_ROWS - 1);

    state_t     state_q, state_d;
    logic [3:0] wr_row_q, wr_row_d;
    logic [2:0] select_q, select_d;

    always_comb begin
        state_d  = state_q;
        wr_row_d = wr_row_q;
        select_d = select_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = FILL;
                    wr_row_d = 4'd0;
                end
            end
            FILL: begin
                if (in_valid) begin
                    if (wr_row_q == LAST_ROW) begin
                        state_d  = READ;
                        wr_row_d = 4'd0;
                        select_d = COL_FIRST;
                    end else begin
                        wr_row_d = wr_row_q + 4'd1;
                    end
                end
            end
            READ: begin
                if (out_ready) begin
                    if (select_q == COL_LAST) begin
                        state_d  = DONE;
                        select_d = SEL_IDLE;
                    end else begin
                        select_d = select_q + 3'd1;
                    end
                end
            end
            DONE: begin
                // A start seen in the DONE cycle chains straight into the next fill.
                state_d  = start ? FILL : IDLE;
                wr_row_d = 4'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_row_q <= 4'd0;
            select_q <= SEL_IDLE;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_row_q <= wr_row_d;
            select_q <= select_d;
            rd_valid <= (state_d == READ);
            busy     <= (state_d == FILL) || (state_d == READ);
            done     <= (state_d == DONE);
        end
    end

    assign wr_en  = in_valid && (state_q == FILL);
    assign wr_row = wr_row_q;
    assign select = select_q;

endmodule

// File: tb/tb_transposed_buffer_ctrl.sv
// Scoreboard bench for transposed_buffer_ctrl: a block-position model predicts every cycle's outputs,
// a separate monitor pops and compares them.
module tb_transposed_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, out_ready;
    logic       busy, wr_en, rd_valid, done;
    logic [3:0] wr_row;
    logic [2:0] select;

    always #5 clk = ~clk;

    transposed_buffer_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .select    (select),
        .rd_valid  (rd_valid),
        .done      (done)
    );

    logic [10:0] exp_q[$];
    int checks   = 0;
    int errors   = 0;
    int pos      = 0;
    int done_exp = 0;
    int done_seen = 0;

    // Block position: 0 idle, 1..11 awaiting row pos-1, 12..15 offering column pos-10, 16 done cycle.
    function automatic logic [10:0] model_out(input int p, input logic iv);
        logic       fill, rd;
        logic [3:0] row;
        logic [2:0] sel;
        fill = (p >= 1) && (p <= 11);
        rd   = (p >= 12) && (p <= 15);
        row  = fill ? 4'(p - 1) : 4'd0;
        sel  = rd ? 3'(p - 10) : 3'd0;
        return {fill || rd, iv && fill, row, sel, rd, p == 16};
    endfunction

    function automatic int model_next(input int p, input logic r, input logic s,
                                      input logic iv, input logic ordy);
        if (r) return 0;
        if (p == 0 || p == 16) return s ? 1 : 0;
        if (p <= 11) return iv ? p + 1 : p;
        return ordy ? p + 1 : p;
    endfunction

    task automatic cyc(input logic r, input logic s, input logic iv, input logic ordy);
        @(negedge clk);
        rst = r; start = s; in_valid = iv; out_ready = ordy;
        exp_q.push_back(model_out(pos, iv));
        if (pos == 16) done_exp++;
        @(posedge clk);
        pos = model_next(pos, r, s, iv, ordy);
    endtask

    task automatic nominal_block();
        cyc(0, 1, 0, 0);
        repeat (20) cyc(0, 0, 1, 1);
    endtask

    always @(negedge clk) begin
        logic [10:0] e, a;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {busy, wr_en, wr_row, select, rd_valid, done};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got busy=%b wr_en=%b wr_row=%0d select=%0d rd_valid=%b done=%b, expected busy=%b wr_en=%b wr_row=%0d select=%0d rd_valid=%b done=%b",
                         $time, a[10], a[9], a[8:5], a[4:2], a[1], a[0],
                         e[10], e[9], e[8:5], e[4:2], e[1], e[0]);
            end
            if (done === 1'b1) done_seen++;
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Reset values, then stray inputs while idle.
        repeat (2) cyc(1, 0, 1, 1);
        repeat (3) cyc(0, 0, 1, 1);

        nominal_block();

        // Fill stalls with ignored start pulses mixed in.
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 30; i++) cyc(0, (i % 5) == 3, (i % 2) == 0, 1);
        repeat (4) cyc(0, 0, 0, 1);

        // Read backpressure while column 3 is offered.
        cyc(0, 1, 0, 0);
        repeat (11) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        repeat (3) cyc(0, 1, 0, 0);
        repeat (5) cyc(0, 0, 0, 1);

        // Start held high across back-to-back blocks.
        repeat (40) cyc(0, 1, 1, 1);
        repeat (3) cyc(0, 0, 0, 0);

        // Reset while column 4 is offered, then a clean block.
        cyc(0, 1, 0, 0);
        repeat (11) cyc(0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 1);
        nominal_block();

        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
        repeat (2) cyc(0, 0, 0, 0);

        @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending, expected 0", exp_q.size());
        end
        checks++;
        if (done_seen != done_exp) begin
            errors++;
            $display("FAIL done_pulses got %0d, expected %0d", done_seen, done_exp);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
